// File: rtl/conv_requant_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_requant_fifo_if
//  Purpose  : Stream bundle for the convolution requantization output stage.
//             It carries the input handshake from the convolution unit, the
//             shift amount, the output stream, and the status outputs.
//  Modports : master - upstream/downstream environment (drives in_*, shift,
//                      out_ready)
//             slave  - the requantization stage itself
//  Revision : 1.0 - initial release
// ============================================================================
interface conv_requant_fifo_if #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32,
   parameter int DEPTH = 4,
   parameter int SH_W  = $clog2(IN_W)
);
   logic [IN_W-1:0]            in_result;
   logic                       in_valid;
   logic                       in_ready;
   logic [SH_W-1:0]            shift;
   logic [OUT_W-1:0]           out_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [$clog2(DEPTH):0]     level;
   logic [15:0]                sat_count;

   modport master (
      output in_result, in_valid, shift, out_ready,
      input  in_ready, out_data, out_valid, level, sat_count
   );

   modport slave (
      input  in_result, in_valid, shift, out_ready,
      output in_ready, out_data, out_valid, level, sat_count
   );
endinterface
`default_nettype wire

// File: rtl/conv_requant_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : conv_requant_fifo
//  Purpose  : Requantizes each accepted unsigned convolution result (right
//             shift with round-half-up, then saturation to OUT_W bits),
//             buffers it in a DEPTH-entry FIFO and presents it on a
//             valid/ready output stream.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - conv_requant_fifo_if.slave: in_result/in_valid/in_ready,
//                    shift, out_data/out_valid/out_ready, level, sat_count
//  Revision : 1.0 - initial release
// ============================================================================
module conv_requant_fifo #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32,
   parameter int DEPTH = 4,
   parameter int SH_W  = $clog2(IN_W)
) (
   input  wire                   clk,
   input  wire                   rst,
   conv_requant_fifo_if.slave    bus
);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_lvl_w = c_ptr_w + 1;
   localparam logic [IN_W:0]    c_one     = (IN_W+1)'(1);
   localparam logic [15:0]      c_sat_max = 16'hFFFF;

   logic [OUT_W-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_lvl_w-1:0] r_level;
   logic [15:0]        r_sat_count;

   logic               w_accept;
   logic               w_pop;
   logic               w_in_ready;
   logic               w_out_valid;
   logic [IN_W:0]      w_round;
   logic [IN_W:0]      w_sum;
   logic [IN_W:0]      w_q;
   logic               w_sat;
   logic [OUT_W-1:0]   w_qval;

   // Requantization runs in IN_W+1 bits so the rounding carry of an
   // all-ones input is kept and forces saturation instead of wrapping.
   always_comb begin
      w_round = '0;
      if (bus.shift != '0) begin
         w_round = c_one << (bus.shift - SH_W'(1));
      end
      w_sum  = {1'b0, bus.in_result} + w_round;
      w_q    = w_sum >> bus.shift;
      w_sat  = |w_q[IN_W:OUT_W];
      w_qval = w_sat ? {OUT_W{1'b1}} : w_q[OUT_W-1:0];
   end

   // No bypass: a full FIFO stays not-ready even while it is being popped.
   assign w_in_ready  = (r_level != c_lvl_w'(DEPTH));
   assign w_out_valid = (r_level != '0);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_ptr] <= w_qval;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_sat_count <= '0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         if (w_accept && !w_pop) begin
            r_level <= r_level + c_lvl_w'(1);
         end else if (w_pop && !w_accept) begin
            r_level <= r_level - c_lvl_w'(1);
         end
         if (w_accept && w_sat && (r_sat_count != c_sat_max)) begin
            r_sat_count <= r_sat_count + 16'd1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
   assign bus.level     = r_level;
   assign bus.sat_count = r_sat_count;

endmodule
`default_nettype wire
